pll_lock_reset_sequencer: RTL and testbench
===========================================

Name: pll_lock_reset_sequencer

Overview:
Parametrised supervisor for a platform PLL wrapper (refclk in, extlock out, active-high PLL reset in). It runs on the free-running reference clock and drives the PLL reset. It qualifies extlock and releases N_CH downstream domain resets in a staged order. On lock loss it re-arms the PLL with a timeout and retry policy. It sits between the PLL wrapper and every clocked subsystem (TEMAC, filter datapath, UART), replacing ad-hoc use of raw extlock as a reset.

Parameters:
N_CH, 3, number of staged downstream reset outputs (1..16)
RST_CYC, 16, refclk cycles the PLL reset is held asserted per attempt (>=1)
LOCK_TIMEOUT, 25000, refclk cycles allowed from PLL reset release to first qualified lock (>=2)
STABLE_CYC, 250, consecutive synchronised-high extlock cycles required before release (>=1)
STAGE_CYC, 8, refclk cycles between successive channel reset releases (>=1)
MAX_RETRY, 4, failed attempts (timeouts) before fail flag sets (>=1)
CNT_W, 8, width of saturating lock-loss counter

Ports:
refclk  in  1  reference clock; only clock of the block
reset  in  1  synchronous active-high reset
extlock  in  1  PLL lock, asynchronous to refclk
pll_rst  out  1  reset to PLL wrapper, active-high
rst_out  out  N_CH  per-domain resets, active-high; bit 0 released first
locked  out  1  high only in RUN (all channels released)
fail  out  1  sticky: MAX_RETRY consecutive timeouts occurred
lock_loss_cnt  out  CNT_W  saturating count of lock losses in RUN or RELEASE

Behaviour:
- Clock and reset: one clock (refclk). Reset is synchronous and active-high (reset).
- While reset is high, or in the cycle it is sampled high: state=PLL_RST, pll_rst=1, rst_out=all 1, locked=0, fail=0, lock_loss_cnt=0, retry count=0, all timers 0.
- extlock passes through a 2-flop synchroniser (extlock_s). It has 2-cycle latency, and the synchroniser flops also clear on reset. All decisions use extlock_s only.
- States:
  - PLL_RST: pll_rst=1. After RST_CYC cycles in this state -> WAIT_LOCK, and pll_rst=0 from the first WAIT_LOCK cycle.
  - WAIT_LOCK: a timeout timer counts from state entry and keeps running through STABLE. If extlock_s=1 -> STABLE.
  - STABLE: counts consecutive extlock_s=1 cycles. A 0 sends the block back to WAIT_LOCK; the stable count clears and the timeout timer does not. At STABLE_CYC consecutive highs -> RELEASE, and the retry count clears.
  - Timeout: when the timer reaches LOCK_TIMEOUT in WAIT_LOCK or STABLE -> PLL_RST and retry++ (saturating). When retry reaches MAX_RETRY, fail=1 (sticky until reset). Retrying continues regardless of fail.
  - RELEASE: on the entry cycle, rst_out[0]=0. rst_out[k] deasserts exactly STAGE_CYC cycles after rst_out[k-1]. On the cycle rst_out[N_CH-1] deasserts -> RUN, and locked=1 in that same cycle.
  - RUN: hold. The block leaves RUN only on lock loss or reset.
- Lock loss: extlock_s=0 in RELEASE or RUN means, on the next cycle, rst_out=all 1, locked=0, state=PLL_RST, lock_loss_cnt++ (saturating at 2^CNT_W-1). Lock loss in WAIT_LOCK or STABLE is not counted.
- rst_out bits never deassert out of order. Once asserted, the whole vector asserts in a single cycle.
- If lock loss and the final stage release coincide, lock loss wins: RUN is not entered and locked stays 0.
- Timers are sized by clog2 of their limit. None wraps; each saturates or clears on state change.
- Reset mid-operation returns the block to the reset values above on the next edge, regardless of state.

Decomposition:
- Package pll_seq_pkg:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN}
  - clog2-based timer width function
  - parameter legality checks (elaboration-time assertions)
- Sub-module sync_2ff: single-bit 2-flop synchroniser with synchronous active-high clear, reusable for other async status bits.

Test Plan:
All scenarios use N_CH=3, RST_CYC=4, LOCK_TIMEOUT=40, STABLE_CYC=8, STAGE_CYC=3, MAX_RETRY=2, CNT_W=4.
1. Nominal lock: reset for 3 cycles, then extlock=1 from cycle 10 and held -> pll_rst low 4 cycles after reset release; rst_out[0] falls 2+8 cycles after extlock rises, then rst_out[1] +3, rst_out[2] +6; locked rises with rst_out[2]; fail=0.
2. Glitchy lock: extlock high 5 cycles, low 1, then steady -> no release until 8 consecutive synchronised highs after the glitch; rst_out stays 3'b111 meanwhile.
3. Timeout and fail: extlock held 0 -> pll_rst re-asserts after 40 WAIT_LOCK cycles for 4 cycles; fail=1 after the 2nd timeout; fail stays 1 when lock later succeeds and locked=1.
4. Lock loss in RUN: drop extlock for 1 cycle -> 2 cycles later rst_out=3'b111, locked=0, pll_rst=1, lock_loss_cnt=1; the full sequence repeats when extlock returns.
5. Loss during RELEASE: drop extlock after rst_out[0] releases -> all resets reassert atomically, lock_loss_cnt increments, RUN never entered; 16 such losses -> lock_loss_cnt saturates at 15.
6. Reset mid-RELEASE: assert reset while rst_out=3'b100 -> next edge gives rst_out=3'b111, pll_rst=1, counters 0, fail=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and elaboration helpers for the PLL lock / reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_seq_state_e;

  // Width of a counter that must hold 0 .. limit-1 (never narrower than 1 bit).
  function automatic int timer_w(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

  function automatic bit params_ok(input int n_ch, input int rst_cyc,
                                   input int lock_timeout, input int stable_cyc,
                                   input int stage_cyc, input int max_retry,
                                   input int cnt_w);
    return (n_ch >= 1) && (n_ch <= 16) && (rst_cyc >= 1) &&
           (lock_timeout >= 2) && (stable_cyc >= 1) && (stage_cyc >= 1) &&
           (max_retry >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Drives the PLL reset, qualifies extlock and releases N_CH domain resets in
// staged order; re-arms the PLL on timeout or lock loss.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int RST_CYC      = 16,
  parameter int LOCK_TIMEOUT = 25000,
  parameter int STABLE_CYC   = 250,
  parameter int STAGE_CYC    = 8,
  parameter int MAX_RETRY    = 4,
  parameter int CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             extlock,
  output logic             pll_rst,
  output logic [N_CH-1:0]  rst_out,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       dbg_state
);

  if (!params_ok(N_CH, RST_CYC, LOCK_TIMEOUT, STABLE_CYC, STAGE_CYC, MAX_RETRY, CNT_W)) begin : g_bad_params
    $error("pll_lock_reset_sequencer: illegal parameter set");
  end

  localparam int REL_SPAN = (N_CH - 1) * STAGE_CYC;
  localparam int RST_W    = timer_w(RST_CYC);
  localparam int TO_W     = timer_w(LOCK_TIMEOUT);
  localparam int STB_W    = timer_w(STABLE_CYC);
  localparam int STG_W    = timer_w(REL_SPAN);
  localparam int RTY_W    = timer_w(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'((N_CH > 1) ? REL_SPAN - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  // Where lock qualification lands: a single channel is fully released at once.
  localparam pll_seq_state_e REL_ENTRY = (N_CH == 1) ? RUN : RELEASE;

  pll_seq_state_e   state, state_d;
  logic [RST_W-1:0] rst_cnt, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic [STB_W-1:0] stb_cnt, stb_cnt_d;
  logic [STG_W-1:0] stg_cnt, stg_cnt_d;
  logic [RTY_W-1:0] retry_cnt, retry_d;
  logic             fail_d;
  logic [CNT_W-1:0] llc_d;
  logic             extlock_s;
  logic             timeout, loss;

  sync_2ff u_sync (
    .clk (refclk),
    .clr (reset),
    .d   (extlock),
    .q   (extlock_s)
  );

  always_ff @(posedge refclk) begin
    if (reset) begin
      state         <= PLL_RST;
      rst_cnt       <= '0;
      to_cnt        <= '0;
      stb_cnt       <= '0;
      stg_cnt       <= '0;
      retry_cnt     <= '0;
      fail          <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_d;
      rst_cnt       <= rst_cnt_d;
      to_cnt        <= to_cnt_d;
      stb_cnt       <= stb_cnt_d;
      stg_cnt       <= stg_cnt_d;
      retry_cnt     <= retry_d;
      fail          <= fail_d;
      lock_loss_cnt <= llc_d;
    end
  end

  // Timers default to zero so each one clears whenever its state is left.
  always_comb begin
    state_d   = state;
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    stg_cnt_d = '0;
    retry_d   = retry_cnt;
    fail_d    = fail;
    llc_d     = lock_loss_cnt;
    timeout   = 1'b0;
    loss      = 1'b0;

    case (state)
      PLL_RST: begin
        if (rst_cnt == RST_LAST) state_d = WAIT_LOCK;
        else rst_cnt_d = rst_cnt + RST_W'(1);
      end
      WAIT_LOCK: begin
        if (to_cnt == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
          if (extlock_s) begin
            if (STABLE_CYC == 1) begin
              state_d = REL_ENTRY;
              retry_d = '0;
            end else begin
              state_d   = STABLE;
              stb_cnt_d = STB_W'(1);
            end
          end
        end
      end
      STABLE: begin
        if (to_cnt == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
          if (!extlock_s) begin
            state_d = WAIT_LOCK;
          end else if (stb_cnt == STB_LAST) begin
            state_d = REL_ENTRY;
            retry_d = '0;
          end else begin
            stb_cnt_d = stb_cnt + STB_W'(1);
          end
        end
      end
      RELEASE: begin
        if (!extlock_s) loss = 1'b1;
        else if (stg_cnt == STG_LAST) state_d = RUN;
        else stg_cnt_d = stg_cnt + STG_W'(1);
      end
      RUN: begin
        if (!extlock_s) loss = 1'b1;
      end
      default: state_d = PLL_RST;
    endcase

    if (timeout) begin
      state_d = PLL_RST;
      if (retry_cnt != RTY_MAX) retry_d = retry_cnt + RTY_W'(1);
      if (retry_d == RTY_MAX) fail_d = 1'b1;
    end

    // Lock loss overrides the final-stage step into RUN.
    if (loss) begin
      state_d = PLL_RST;
      if (lock_loss_cnt != '1) llc_d = lock_loss_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rst_out = '1;
    for (int k = 0; k < N_CH; k++) begin
      if (state == RUN) rst_out[k] = 1'b0;
      else if (state == RELEASE && int'(stg_cnt) >= k * STAGE_CYC) rst_out[k] = 1'b0;
    end
  end

  assign pll_rst   = (state == PLL_RST);
  assign locked    = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for the PLL lock / reset sequencer with hand-derived cycle timing.
module tb_pll_lock_reset_sequencer;

  localparam int N_CH = 3;
  localparam int CNT_W = 4;

  logic             refclk = 1'b0;
  logic             reset;
  logic             extlock;
  logic             pll_rst;
  logic [N_CH-1:0]  rst_out;
  logic             locked;
  logic             fail;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [2:0]       dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  pll_lock_reset_sequencer #(
    .N_CH(N_CH), .RST_CYC(4), .LOCK_TIMEOUT(40), .STABLE_CYC(8),
    .STAGE_CYC(3), .MAX_RETRY(2), .CNT_W(CNT_W)
  ) dut (
    .refclk        (refclk),
    .reset         (reset),
    .extlock       (extlock),
    .pll_rst       (pll_rst),
    .rst_out       (rst_out),
    .locked        (locked),
    .fail          (fail),
    .lock_loss_cnt (lock_loss_cnt),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    extlock = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_locked(input int budget, output int n);
    n = 0;
    while (!locked && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rst_out(input string tag, input logic [N_CH-1:0] v, input int budget);
    int n;
    n = 0;
    while (rst_out !== v && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(rst_out), 32'(v));
  endtask

  initial begin
    int n;
    logic [CNT_W-1:0] exp_llc;

    // 1. nominal lock
    reset   = 1'b1;
    extlock = 1'b0;
    tick(3);
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_rst_out", 32'(rst_out), 32'h7);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_llc", 32'(lock_loss_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick(3);
    chk("s1_pll_rst_held", 32'(pll_rst), 32'd1);
    tick();
    chk("s1_pll_rst_rel", 32'(pll_rst), 32'd0);
    chk("s1_wait_lock", 32'(dbg_state), 32'd1);
    tick(5);
    extlock = 1'b1;
    tick(9);
    chk("s1_pre_rel", 32'(rst_out), 32'h7);
    tick();
    chk("s1_rel0", 32'(rst_out), 32'h6);
    chk("s1_rel0_locked", 32'(locked), 32'd0);
    tick(2);
    chk("s1_rel0_hold", 32'(rst_out), 32'h6);
    tick();
    chk("s1_rel1", 32'(rst_out), 32'h4);
    tick(2);
    chk("s1_rel1_locked", 32'(locked), 32'd0);
    tick();
    chk("s1_rel2", 32'(rst_out), 32'h0);
    chk("s1_locked", 32'(locked), 32'd1);
    chk("s1_fail", 32'(fail), 32'd0);

    // 4. one-cycle lock loss in RUN: 2 sync flops, then one decision cycle
    extlock = 1'b0;
    tick();
    extlock = 1'b1;
    tick();
    chk("s4_still_locked", 32'(locked), 32'd1);
    tick();
    chk("s4_rst_out", 32'(rst_out), 32'h7);
    chk("s4_locked", 32'(locked), 32'd0);
    chk("s4_pll_rst", 32'(pll_rst), 32'd1);
    chk("s4_llc", 32'(lock_loss_cnt), 32'd1);
    // 4 PLL_RST + 1 WAIT_LOCK + 7 STABLE + 6 RELEASE cycles
    wait_locked(50, n);
    chk("s4_relock_cycles", 32'(n), 32'd18);

    // 2. glitchy lock
    do_reset();
    tick(4);
    extlock = 1'b1;
    tick(5);
    extlock = 1'b0;
    tick();
    extlock = 1'b1;
    tick();
    chk("s2_stable_pre_glitch", 32'(dbg_state), 32'd2);
    tick();
    chk("s2_back_to_wait", 32'(dbg_state), 32'd1);
    chk("s2_rst_hold", 32'(rst_out), 32'h7);
    tick(7);
    chk("s2_pre_rel", 32'(rst_out), 32'h7);
    tick();
    chk("s2_rel0", 32'(rst_out), 32'h6);

    // 3. timeout and fail
    do_reset();
    tick(43);
    chk("s3_to1_pre", 32'(pll_rst), 32'd0);
    tick();
    chk("s3_to1_pll_rst", 32'(pll_rst), 32'd1);
    chk("s3_to1_fail", 32'(fail), 32'd0);
    tick(3);
    chk("s3_rearm_held", 32'(pll_rst), 32'd1);
    tick();
    chk("s3_rearm_rel", 32'(pll_rst), 32'd0);
    tick(39);
    chk("s3_to2_pre_fail", 32'(fail), 32'd0);
    chk("s3_to2_pre_pll", 32'(pll_rst), 32'd0);
    tick();
    chk("s3_to2_fail", 32'(fail), 32'd1);
    chk("s3_to2_pll_rst", 32'(pll_rst), 32'd1);
    extlock = 1'b1;
    wait_locked(60, n);
    chk("s3_lock_cycles", 32'(n), 32'd18);
    chk("s3_fail_sticky", 32'(fail), 32'd1);

    // 5. repeated loss during RELEASE, counter saturation
    extlock = 1'b0;
    tick(3);
    chk("s5_run_loss_llc", 32'(lock_loss_cnt), 32'd1);
    extlock = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_rst_out("s5_wait_rel0", 3'b110, 100);
      extlock = 1'b0;
      tick(2);
      chk("s5_no_rel1", 32'(rst_out), 32'h6);
      tick();
      exp_llc = (i + 2 > 15) ? 4'd15 : CNT_W'(i + 2);
      chk("s5_reassert", 32'(rst_out), 32'h7);
      chk("s5_not_locked", 32'(locked), 32'd0);
      chk("s5_llc", 32'(lock_loss_cnt), 32'(exp_llc));
      extlock = 1'b1;
    end

    // 6. reset mid-RELEASE
    wait_rst_out("s6_wait_rel1", 3'b100, 100);
    chk("s6_fail_before", 32'(fail), 32'd1);
    reset = 1'b1;
    tick();
    chk("s6_rst_out", 32'(rst_out), 32'h7);
    chk("s6_pll_rst", 32'(pll_rst), 32'd1);
    chk("s6_llc", 32'(lock_loss_cnt), 32'd0);
    chk("s6_fail", 32'(fail), 32'd0);
    chk("s6_locked", 32'(locked), 32'd0);
    chk("s6_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
